// File: rtl/bits4_add_sub_unit_pkg.sv
// Shared widths and types for the registered nibble adder/subtractor.
package bits4_add_sub_unit_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned RES_W    = NIBBLE_W + 1;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [RES_W-1:0]    res_t;

  // Contents of the output register bank.
  typedef struct packed {
    logic valid;
    res_t m;
    res_t s;
    logic s_zero;
  } out_bank_t;

  localparam out_bank_t OutBankReset = '{valid: 1'b0, m: '0, s: '0, s_zero: 1'b0};

endpackage

// File: rtl/bits4_add_sub_unit_full_adder.sv
// Single-bit full adder used as the ripple-chain cell.
module bits4_add_sub_unit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/bits4_add_sub_unit.sv
// Registered 4-bit unsigned adder/subtractor: sum and difference of two nibbles,
// each as a 5-bit result, one registered stage with a valid strobe.
module bits4_add_sub_unit
  import bits4_add_sub_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                out_valid,
  output logic [RES_W-1:0]    m,
  output logic [RES_W-1:0]    s,
  output logic                s_zero
);

  logic [NIBBLE_W:0]   add_c;
  logic [NIBBLE_W:0]   sub_c;
  logic [NIBBLE_W-1:0] add_sum;
  logic [NIBBLE_W-1:0] sub_sum;
  nibble_t             b_n;

  out_bank_t bank_d;
  out_bank_t bank_q;

  // Subtraction is A + ~B + 1: the inverted operand with the chain's carry-in forced high.
  assign b_n      = ~b;
  assign add_c[0] = 1'b0;
  assign sub_c[0] = 1'b1;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_chain
    bits4_add_sub_unit_full_adder u_add_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (add_c[i]),
      .sum  (add_sum[i]),
      .cout (add_c[i+1])
    );

    bits4_add_sub_unit_full_adder u_sub_fa (
      .a    (a[i]),
      .b    (b_n[i]),
      .cin  (sub_c[i]),
      .sum  (sub_sum[i]),
      .cout (sub_c[i+1])
    );
  end

  always_comb begin
    bank_d       = bank_q;
    bank_d.valid = in_valid;
    if (in_valid) begin
      bank_d.m      = {add_c[NIBBLE_W], add_sum};
      // No carry-out of A + ~B + 1 means A < B, i.e. a borrow.
      bank_d.s      = {~sub_c[NIBBLE_W], sub_sum};
      bank_d.s_zero = ~|{~sub_c[NIBBLE_W], sub_sum};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= OutBankReset;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign out_valid = bank_q.valid;
  assign m         = bank_q.m;
  assign s         = bank_q.s;
  assign s_zero    = bank_q.s_zero;

endmodule

// File: tb/tb_bits4_add_sub_unit.sv
// Directed-vector and exhaustive bench for bits4_add_sub_unit.
module tb_bits4_add_sub_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic [4:0] m;
  logic [4:0] s;
  logic       s_zero;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] m;
    logic [4:0] s;
    logic       z;
  } vec_t;

  vec_t vecs[11];

  bits4_add_sub_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .m         (m),
    .s         (s),
    .s_zero    (s_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic ov, input logic [4:0] em,
                           input logic [4:0] es, input logic ez);
    check({name, ".out_valid"}, {7'b0, out_valid}, {7'b0, ov});
    check({name, ".m"}, {3'b0, m}, {3'b0, em});
    check({name, ".s"}, {3'b0, s}, {3'b0, es});
    check({name, ".s_zero"}, {7'b0, s_zero}, {7'b0, ez});
  endtask

  // Drive on the falling edge, sample 1 ns after the following rising edge.
  task automatic apply(input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_m;
    int exp_s;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{4'd6,  4'd10, 5'b10000, 5'b11100, 1'b0};
    vecs[1]  = '{4'd0,  4'd12, 5'b01100, 5'b10100, 1'b0};
    vecs[2]  = '{4'd4,  4'd9,  5'b01101, 5'b11011, 1'b0};
    vecs[3]  = '{4'd2,  4'd1,  5'b00011, 5'b00001, 1'b0};
    vecs[4]  = '{4'd11, 4'd3,  5'b01110, 5'b01000, 1'b0};
    vecs[5]  = '{4'd14, 4'd13, 5'b11011, 5'b00001, 1'b0};
    vecs[6]  = '{4'd10, 4'd15, 5'b11001, 5'b11011, 1'b0};
    vecs[7]  = '{4'd7,  4'd14, 5'b10101, 5'b11001, 1'b0};
    vecs[8]  = '{4'd0,  4'd3,  5'b00011, 5'b11101, 1'b0};
    vecs[9]  = '{4'd2,  4'd8,  5'b01010, 5'b11010, 1'b0};
    vecs[10] = '{4'd9,  4'd9,  5'b10010, 5'b00000, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    #2;
    check_all("reset", 1'b0, 5'd0, 5'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 4'd5, 4'd5);
    check_all("idle_after_reset", 1'b0, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      apply(1'b1, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].m, vecs[i].s, vecs[i].z);
    end

    // Last vector was 9,9: results must hold while in_valid is low.
    apply(1'b0, 4'd3, 4'd12);
    check_all("hold", 1'b0, 5'b10010, 5'b00000, 1'b1);
    apply(1'b0, 4'd15, 4'd0);
    check_all("hold2", 1'b0, 5'b10010, 5'b00000, 1'b1);

    for (int x = 0; x < 256; x++) begin
      apply(1'b1, x[7:4], x[3:0]);
      exp_m = x[7:4] + x[3:0];
      exp_s = (int'(x[7:4]) - int'(x[3:0])) & 31;
      check_all($sformatf("exh_a%0d_b%0d", x[7:4], x[3:0]), 1'b1, exp_m[4:0], exp_s[4:0],
                x[7:4] == x[3:0]);
    end

    // Reset mid-stream: clears immediately, no clock edge required.
    apply(1'b1, 4'd15, 4'd15);
    check_all("pre_rst", 1'b1, 5'b11110, 5'b00000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd12;
    b        = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 4'd3, 4'd7);
    check_all("post_rst", 1'b1, 5'b01010, 5'b11100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
